// File: rtl/imem_loader_if.sv
// Loader bus bundle: framed byte-stream handshake in, single-word memory write port out.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  // master: stream source and memory sink; slave: the loader itself
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Program loader: parses SYNC/ADDR/COUNT/data/CHECKSUM byte frames into 16-bit memory writes.
// Optional inter-byte timeout enabled with `define LOADER_TIMEOUT_EN.
module imem_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  imem_loader_if.slave bus,
  input  logic        restart,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("imem_loader: TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_HI,
    S_LO,
    S_CKSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CKSUM   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_e            state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        cnt_q;
  logic [7:0]        hi_q;
  logic [7:0]        sum_q;

  logic accept_c;
  assign accept_c = bus.in_valid && in_ready_q;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_q;
  logic             active_c;
  logic             expire_c;

  // Timer only runs while a frame is in flight and no byte arrives
  assign active_c = (state_q inside {S_ADDR, S_COUNT, S_HI, S_LO, S_CKSUM});
  assign expire_c = active_c && !accept_c && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
`ifdef LOADER_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      // Every transition happens on an accepted byte, so this also clears on state entry
      if (accept_c || !active_c) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TMR_W'(1);
      end
`endif
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_c && (bus.in_data == SYNC_BYTE)) begin
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (accept_c) begin
            ptr_q   <= ADDR_W'(bus.in_data);
            sum_q   <= bus.in_data;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (accept_c) begin
            cnt_q   <= bus.in_data;
            sum_q   <= sum_q + bus.in_data;
            state_q <= (bus.in_data == 8'd0) ? S_CKSUM : S_HI;
          end
        end
        S_HI: begin
          if (accept_c) begin
            hi_q    <= bus.in_data;
            sum_q   <= sum_q + bus.in_data;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (accept_c) begin
            sum_q       <= sum_q + bus.in_data;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= {hi_q, bus.in_data};
            ptr_q       <= ptr_q + ADDR_W'(1);
            cnt_q       <= cnt_q - 8'd1;
            state_q     <= (cnt_q == 8'd1) ? S_CKSUM : S_HI;
          end
        end
        S_CKSUM: begin
          if (accept_c) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == sum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= S_ERROR;
              err_q      <= 1'b1;
              err_code_q <= ERR_CKSUM;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            cpu_hold_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
`ifdef LOADER_TIMEOUT_EN
      if (expire_c) begin
        state_q    <= S_ERROR;
        in_ready_q <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule
